// File: rtl/output_page_selector_pkg.sv
// Shared display-selector definitions: mode encodings and a
// constant-safe ceil(log2) helper.
package output_page_selector_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_FREEZE = 2'b10,
    MODE_DIRECT = 2'b11
  } mode_e;

  function automatic int clog2(input int n);
    int r;
    longint v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/output_page_selector_page_sequencer.sv
// Page sequencer: step edge detect, dwell timer, page register
// and page-change pulse.
module page_sequencer
  import output_page_selector_pkg::*;
#(
  parameter int DWELL     = 4,
  parameter int NUM_PAGES = 4,
  parameter int PW        = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic          step,
  input  logic [PW-1:0] page_sel,
  output logic [PW-1:0] page,
  output logic          page_chg
);

  localparam int CW =
    (clog2(DWELL) < 1) ? 1 : clog2(DWELL);

  mode_e         mode_cur;
  mode_e         mode_q;
  logic          step_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [PW-1:0] page_nxt;
  logic [PW-1:0] page_inc;

  assign mode_cur = mode_e'(mode);
  assign page_inc =
    (page == PW'(NUM_PAGES - 1)) ? '0 : page + 1'b1;

  // A mode change only restarts the dwell; the page holds that cycle.
  always_comb begin
    cnt_nxt  = cnt;
    page_nxt = page;
    if (mode_cur != mode_q) begin
      cnt_nxt = '0;
    end else begin
      unique case (1'b1)
        (mode_cur == MODE_MANUAL): begin
          if (step && !step_q) page_nxt = page_inc;
        end
        (mode_cur == MODE_AUTO): begin
          if (cnt == CW'(DWELL - 1)) begin
            cnt_nxt  = '0;
            page_nxt = page_inc;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        (mode_cur == MODE_DIRECT): begin
          if (int'(page_sel) < NUM_PAGES) page_nxt = page_sel;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      page     <= '0;
      cnt      <= '0;
      step_q   <= 1'b0;
      mode_q   <= mode_cur;
      page_chg <= 1'b0;
    end else begin
      page     <= page_nxt;
      cnt      <= cnt_nxt;
      step_q   <= step;
      mode_q   <= mode_cur;
      page_chg <= (page_nxt != page);
    end
  end

endmodule

// File: rtl/output_page_selector.sv
// Paged source-nibble selector driving registered display lanes.
// Short last pages are zero-filled.
module output_page_selector
  import output_page_selector_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int NUM_SRC   = 8,
  parameter  int NUM_OUT   = 2,
  parameter  int DWELL     = 50_000_000,
  localparam int NUM_PAGES = (NUM_SRC + NUM_OUT - 1) / NUM_OUT,
  localparam int PW        =
    (clog2(NUM_PAGES) < 1) ? 1 : clog2(NUM_PAGES)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_SRC*WIDTH-1:0] SRC,
  input  logic [1:0]               MODE,
  input  logic                     STEP,
  input  logic [PW-1:0]            PAGE_SEL,
  output logic [NUM_OUT*WIDTH-1:0] OUT,
  output logic [PW-1:0]            PAGE,
  output logic                     PAGE_CHG
);

  localparam int NP2 = 1 << PW;

  typedef logic [NUM_OUT-1:0][WIDTH-1:0] lanes_t;

  lanes_t pages [NP2];

  for (genvar p = 0; p < NP2; p++) begin : g_page
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
      if (p * NUM_OUT + k < NUM_SRC) begin : g_src
        assign pages[p][k] =
          SRC[(p*NUM_OUT+k)*WIDTH +: WIDTH];
      end else begin : g_pad
        assign pages[p][k] = '0;
      end
    end
  end

  page_sequencer #(
    .DWELL     (DWELL),
    .NUM_PAGES (NUM_PAGES),
    .PW        (PW)
  ) u_seq (
    .clk      (CLK),
    .reset    (RESET),
    .mode     (MODE),
    .step     (STEP),
    .page_sel (PAGE_SEL),
    .page     (PAGE),
    .page_chg (PAGE_CHG)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT <= '0;
    end else if (mode_e'(MODE) != MODE_FREEZE) begin
      OUT <= pages[PAGE];
    end
  end

endmodule

// File: doc/output_page_selector.md
Name: output_page_selector

Overview:
Parametrised successor to the ALU board's two-lane output selector. Gathers NUM_SRC data nibbles (switches, instruction halves, index, accumulator, status, …) into pages of NUM_OUT lanes and drives them onto registered output lanes for LEDs or 7-seg. The page is chosen manually by a step button, automatically on a dwell timer, directly by page-select inputs, or frozen. The block sits between the datapath registers and the board display drivers.

Parameters:
WIDTH, 4, bits per source nibble and per output lane
NUM_SRC, 8, number of source nibbles on SRC
NUM_OUT, 2, number of output lanes per page
DWELL, 50_000_000, clock cycles per page in AUTO mode (must be ≥1)
NUM_PAGES, derived localparam = ceil(NUM_SRC/NUM_OUT)
PW, derived localparam = max(1, clog2(NUM_PAGES))

Ports:
CLK  input  1  system clock, all logic on the rising edge
RESET  input  1  synchronous, active-high reset
SRC  input  NUM_SRC*WIDTH  packed sources; nibble i = SRC[i*WIDTH +: WIDTH]
MODE  input  2  00 MANUAL, 01 AUTO, 10 FREEZE, 11 DIRECT
STEP  input  1  level from the page-advance button, already debounced
PAGE_SEL  input  PW  page number used in DIRECT mode
OUT  output  NUM_OUT*WIDTH  lane k = OUT[k*WIDTH +: WIDTH]
PAGE  output  PW  page currently displayed
PAGE_CHG  output  1  one-cycle pulse when PAGE changes value

Behaviour:
- Reset (synchronous, RESET=1 at the clock edge): page=0, OUT=0, PAGE_CHG=0, dwell counter=0, STEP history register=0. Reset takes precedence over every mode and any operation in progress.
- Lane mapping: lane k on page p shows nibble p*NUM_OUT+k. If that index is ≥ NUM_SRC (partial last page), the lane shows 0.
- OUT is registered from the current page and SRC: 1-cycle latency from a SRC change or a page change to OUT.
- MANUAL (00): a rising edge on STEP (STEP=1 with previous sample 0) advances the page by 1. The page wraps from NUM_PAGES-1 to 0. A held STEP advances only once.
- AUTO (01): the dwell counter counts 0..DWELL-1. On the terminal count it returns to 0 and the page advances, with wrap. STEP is ignored.
- FREEZE (10): page, OUT and dwell counter all hold, even if SRC changes. The STEP history still samples, so leaving FREEZE with STEP already high does not create an edge.
- DIRECT (11): page <= PAGE_SEL when PAGE_SEL < NUM_PAGES. An out-of-range PAGE_SEL holds the current page.
- Any MODE change clears the dwell counter in that cycle. The page is kept.
- Simultaneous events: RESET has priority over MODE. In MANUAL, a STEP edge in the same cycle as a MODE change is ignored.
- PAGE_CHG=1 in the cycle after the page register takes a different value. Rewriting the same page in DIRECT does not pulse.
- NUM_PAGES=1: page is fixed at 0 and PAGE_CHG never asserts.

Decomposition:
- Shared package: MODE encodings (MODE_MANUAL, MODE_AUTO, MODE_FREEZE, MODE_DIRECT) and a clog2 function. The ALU top-level and the board-switch decoder reuse them.
- One natural sub-module: page_sequencer, containing the edge detect, dwell counter, page register and PAGE_CHG. The lane mux and output register stay in the top module.

Test Plan:
Defaults, DWELL=4. SRC nibbles 0..7 = {6,2,5,A,F,3,C,0} (switches lo/hi, instruction lo/hi, index, acc, status, pad).
1. Reset: RESET high for 2 cycles, then low, MODE=00 -> OUT=0x00 during reset. One cycle after release: PAGE=0, OUT lanes {6,2}, PAGE_CHG=0.
2. Manual steps: 5 single-cycle STEP pulses -> PAGE goes 1,2,3,0,1 and OUT lanes go {5,A},{F,3},{C,0},{6,2},{5,A}. PAGE_CHG pulses once per step. STEP held 10 cycles -> exactly one advance.
3. Auto: MODE=01 for 17 cycles from page 0 -> the page advances every 4 cycles to 1,2,3,0. Switching to MANUAL mid-dwell, then back to AUTO -> the next advance comes a full 4 cycles later.
4. Freeze: on page 2, MODE=10, then change SRC nibble 4 from F to 7 -> OUT stays {F,3}. Return to MANUAL -> OUT={7,3} on the next cycle.
5. Direct: MODE=11 with PAGE_SEL=3 -> OUT={C,0}. PAGE_SEL=3 held -> no further PAGE_CHG. NUM_SRC=7 build, page 3 -> OUT={C,0} (lane 1 zero-filled).
6. Reset mid-operation: RESET asserted in AUTO at dwell count 2 on page 3 -> next cycle PAGE=0, OUT=0, dwell counter=0.
